inert_intf: RTL and testbench

- SPI front end for the 6-axis IMU.
- Powers up and configures the IMU, then waits for each data-ready interrupt.
- On each interrupt, reads pitch rate and Z acceleration as byte pairs and presents them as signed 16-bit words with a one-cycle vld strobe.
- Feeds the inertial integrator directly (ptch_rt, AZ, vld).

---
 rtl/inert_intf_pkg.sv | 48 ++++
 rtl/SPI_mnrch.sv | 111 +++++++++++
 rtl/inert_intf.sv | 190 +++++++++++++++++++
 tb/tb_inert_intf.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inert_intf_pkg.sv
// Shared types and constants for the IMU SPI front end: FSM encodings,
// configuration writes and data register read addresses.
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    CFG      = 3'd1,
    WAIT_INT = 3'd2,
    RD_PL    = 3'd3,
    RD_PH    = 3'd4,
    RD_AL    = 3'd5,
    RD_AH    = 3'd6,
    VLD      = 3'd7
  } inert_state_t;

  typedef enum logic [1:0] {
    SPI_IDLE   = 2'd0,
    SPI_ACTIVE = 2'd1,
    SPI_TAIL   = 2'd2
  } spi_state_t;

  localparam logic [15:0] CFG_INT1  = 16'h0D02;
  localparam logic [15:0] CFG_ACCEL = 16'h1053;
  localparam logic [15:0] CFG_GYRO  = 16'h1150;
  localparam logic [15:0] CFG_ROUND = 16'h1460;

  localparam logic [7:0] PTCH_L = 8'hA4;
  localparam logic [7:0] PTCH_H = 8'hA5;
  localparam logic [7:0] AZ_L   = 8'hAC;
  localparam logic [7:0] AZ_H   = 8'hAD;

  function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
    logic [15:0] cmd;
    case (idx)
      2'd0:    cmd = CFG_INT1;
      2'd1:    cmd = CFG_ACCEL;
      2'd2:    cmd = CFG_GYRO;
      2'd3:    cmd = CFG_ROUND;
      default: cmd = CFG_INT1;
    endcase
    return cmd;
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
    return {addr, 8'h00};
  endfunction

endpackage

// File: rtl/SPI_mnrch.sv
// 16-bit SPI mode-3 master: SCLK idles high, MOSI shifts on the falling edge,
// MISO is captured on the rising edge, MSB first.
module SPI_mnrch
  import inert_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_HALF = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = {SCLK_DIV_W{1'b1}};

  spi_state_t            state_r, state_s;
  logic [SCLK_DIV_W-1:0] div_r, div_s;
  logic [4:0]            bit_cnt_r, bit_cnt_s;
  logic [15:0]           shft_r, shft_s;
  logic                  miso_r, miso_s;
  logic                  ss_n_r, ss_n_s;
  logic                  done_r, done_s;

  // Next-state: the first fall only launches the MSB; the 17th would-be fall ends the frame.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_cnt_s = bit_cnt_r;
    shft_s    = shft_r;
    miso_s    = miso_r;
    ss_n_s    = ss_n_r;
    done_s    = 1'b0;
    case (state_r)
      SPI_IDLE: begin
        if (wrt) begin
          shft_s    = cmd;
          div_s     = DIV_HALF;
          bit_cnt_s = 5'd0;
          ss_n_s    = 1'b0;
          state_s   = SPI_ACTIVE;
        end else begin
          div_s  = DIV_HALF;
          ss_n_s = 1'b1;
        end
      end
      SPI_ACTIVE: begin
        if ((div_r == DIV_FALL) && (bit_cnt_r == 5'd16)) begin
          shft_s  = {shft_r[14:0], miso_r};
          div_s   = DIV_HALF;
          ss_n_s  = 1'b1;
          state_s = SPI_TAIL;
        end else begin
          div_s = div_r + SCLK_DIV_W'(1);
          if (div_r == DIV_RISE) begin
            miso_s    = MISO;
            bit_cnt_s = bit_cnt_r + 5'd1;
          end else if ((div_r == DIV_FALL) && (bit_cnt_r != 5'd0)) begin
            shft_s = {shft_r[14:0], miso_r};
          end else begin
            shft_s = shft_r;
          end
        end
      end
      SPI_TAIL: begin
        done_s  = 1'b1;
        state_s = SPI_IDLE;
      end
      default: begin
        div_s   = DIV_HALF;
        ss_n_s  = 1'b1;
        state_s = SPI_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset parks SCLK high and deselects the IMU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= SPI_IDLE;
      div_r     <= DIV_HALF;
      bit_cnt_r <= 5'd0;
      shft_r    <= 16'h0000;
      miso_r    <= 1'b0;
      ss_n_r    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_cnt_r <= bit_cnt_s;
      shft_r    <= shft_s;
      miso_r    <= miso_s;
      ss_n_r    <= ss_n_s;
      done_r    <= done_s;
    end
  end

  assign SS_n    = ss_n_r;
  assign SCLK    = div_r[SCLK_DIV_W-1];
  assign MOSI    = shft_r[15];
  assign done    = done_r;
  assign rd_data = shft_r;

endmodule

// File: rtl/inert_intf.sv
// IMU front end: power-up wait, configuration writes, then a four-read burst per
// data-ready interrupt, publishing pitch rate and Z acceleration with a vld strobe.
module inert_intf
  import inert_pkg::*;
#(
  parameter int SCLK_DIV_W = 5,
  parameter int PWRUP_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld
);

  inert_state_t       state_r, state_s;
  logic [PWRUP_W-1:0] pwr_cnt_r, pwr_cnt_s;
  logic [1:0]         cfg_idx_r, cfg_idx_s;
  logic               int_ff1_r, int_ff2_r;
  logic [7:0]         ptch_l_r, ptch_l_s, ptch_h_r, ptch_h_s;
  logic [7:0]         az_l_r, az_l_s, az_h_r, az_h_s;
  logic [15:0]        ptch_rt_r, ptch_rt_s, az_r, az_s;
  logic               vld_r, vld_s;
  logic               wrt_s;
  logic [15:0]        cmd_s;
  logic               spi_done_s;
  logic [15:0]        rd_data_s;
  logic               unused_rd_hi_s;

  SPI_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt_s),
    .cmd     (cmd_s),
    .done    (spi_done_s),
    .rd_data (rd_data_s),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // The byte clocked out while the address goes in carries no data.
  assign unused_rd_hi_s = ^rd_data_s[15:8];

  // Two-flop synchronizer for the asynchronous data-ready line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ff1_r <= 1'b0;
      int_ff2_r <= 1'b0;
    end else begin
      int_ff1_r <= INT;
      int_ff2_r <= int_ff1_r;
    end
  end

  // Sequencer: every command is launched on the cycle its predecessor's done is seen.
  always_comb begin
    state_s   = state_r;
    pwr_cnt_s = pwr_cnt_r;
    cfg_idx_s = cfg_idx_r;
    ptch_l_s  = ptch_l_r;
    ptch_h_s  = ptch_h_r;
    az_l_s    = az_l_r;
    az_h_s    = az_h_r;
    ptch_rt_s = ptch_rt_r;
    az_s      = az_r;
    vld_s     = 1'b0;
    wrt_s     = 1'b0;
    cmd_s     = 16'h0000;
    case (state_r)
      PWRUP: begin
        if (&pwr_cnt_r) begin
          cfg_idx_s = 2'd0;
          wrt_s     = 1'b1;
          cmd_s     = cfg_cmd(2'd0);
          state_s   = CFG;
        end else begin
          pwr_cnt_s = pwr_cnt_r + PWRUP_W'(1);
        end
      end
      CFG: begin
        if (spi_done_s) begin
          if (cfg_idx_r == 2'd3) begin
            state_s = WAIT_INT;
          end else begin
            cfg_idx_s = cfg_idx_r + 2'd1;
            wrt_s     = 1'b1;
            cmd_s     = cfg_cmd(cfg_idx_r + 2'd1);
          end
        end else begin
          state_s = CFG;
        end
      end
      WAIT_INT: begin
        if (int_ff2_r) begin
          wrt_s   = 1'b1;
          cmd_s   = rd_cmd(PTCH_L);
          state_s = RD_PL;
        end else begin
          state_s = WAIT_INT;
        end
      end
      RD_PL: begin
        if (spi_done_s) begin
          ptch_l_s = rd_data_s[7:0];
          wrt_s    = 1'b1;
          cmd_s    = rd_cmd(PTCH_H);
          state_s  = RD_PH;
        end else begin
          state_s = RD_PL;
        end
      end
      RD_PH: begin
        if (spi_done_s) begin
          ptch_h_s = rd_data_s[7:0];
          wrt_s    = 1'b1;
          cmd_s    = rd_cmd(AZ_L);
          state_s  = RD_AL;
        end else begin
          state_s = RD_PH;
        end
      end
      RD_AL: begin
        if (spi_done_s) begin
          az_l_s  = rd_data_s[7:0];
          wrt_s   = 1'b1;
          cmd_s   = rd_cmd(AZ_H);
          state_s = RD_AH;
        end else begin
          state_s = RD_AL;
        end
      end
      RD_AH: begin
        if (spi_done_s) begin
          az_h_s  = rd_data_s[7:0];
          state_s = VLD;
        end else begin
          state_s = RD_AH;
        end
      end
      VLD: begin
        vld_s     = 1'b1;
        ptch_rt_s = {ptch_h_r, ptch_l_r};
        az_s      = {az_h_r, az_l_r};
        state_s   = WAIT_INT;
      end
      default: begin
        state_s = PWRUP;
      end
    endcase
  end

  // Sequencer state, burst byte registers and the coherent output holding pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= PWRUP;
      pwr_cnt_r <= '0;
      cfg_idx_r <= 2'd0;
      ptch_l_r  <= 8'h00;
      ptch_h_r  <= 8'h00;
      az_l_r    <= 8'h00;
      az_h_r    <= 8'h00;
      ptch_rt_r <= 16'h0000;
      az_r      <= 16'h0000;
      vld_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pwr_cnt_r <= pwr_cnt_s;
      cfg_idx_r <= cfg_idx_s;
      ptch_l_r  <= ptch_l_s;
      ptch_h_r  <= ptch_h_s;
      az_l_r    <= az_l_s;
      az_h_r    <= az_h_s;
      ptch_rt_r <= ptch_rt_s;
      az_r      <= az_s;
      vld_r     <= vld_s;
    end
  end

  assign ptch_rt = ptch_rt_r;
  assign AZ      = az_r;
  assign vld     = vld_r;

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf with a behavioural mode-3 IMU slave model.
module tb_inert_intf;

  localparam int SCLK_DIV_W = 4;
  localparam int PWRUP_W    = 6;
  localparam int BUDGET     = 20000;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        INT  = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, vld;
  logic [15:0] ptch_rt, AZ;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inert_intf #(.SCLK_DIV_W(SCLK_DIV_W), .PWRUP_W(PWRUP_W)) dut (
    .clk(clk), .rst(rst), .INT(INT), .MISO(MISO), .SS_n(SS_n), .SCLK(SCLK),
    .MOSI(MOSI), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );

  // IMU register contents returned for reads
  logic [7:0]  reg_a4 = 8'h34, reg_a5 = 8'h12, reg_ac = 8'hCD, reg_ad = 8'hAB;
  logic [15:0] mosi_sh = 16'h0000;
  logic [7:0]  addr_r  = 8'h00;
  logic [7:0]  resp_s;
  int          rx_cnt  = 0;
  logic [15:0] frames [0:63];
  int          nfr     = 0;

  always_comb begin
    case (addr_r)
      8'hA4:   resp_s = reg_a4;
      8'hA5:   resp_s = reg_a5;
      8'hAC:   resp_s = reg_ac;
      8'hAD:   resp_s = reg_ad;
      default: resp_s = 8'h00;
    endcase
  end

  // Slave receive side: logs only complete 16-bit frames
  always @(posedge SCLK or posedge SS_n) begin
    if (SS_n) begin
      if (rx_cnt == 16 && nfr < 64) begin
        frames[nfr] <= mosi_sh;
        nfr <= nfr + 1;
      end
      rx_cnt <= 0;
    end else begin
      mosi_sh <= {mosi_sh[14:0], MOSI};
      if (rx_cnt == 7) addr_r <= {mosi_sh[6:0], MOSI};
      rx_cnt <= rx_cnt + 1;
    end
  end

  // Slave transmit side: data byte in the second half of the frame
  always @(negedge SCLK) begin
    if (!SS_n) begin
      if (rx_cnt >= 8) MISO <= resp_s[3'(15 - rx_cnt)];
      else MISO <= 1'b0;
    end
  end

  int          nvld = 0;
  int          wide_cnt = 0;
  logic        vld_prev = 1'b0;
  logic [15:0] cap_p [0:15];
  logic [15:0] cap_a [0:15];

  // vld monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      if (nvld < 16) begin
        cap_p[nvld] <= ptch_rt;
        cap_a[nvld] <= AZ;
      end
      nvld <= nvld + 1;
      if (vld_prev) wide_cnt <= wide_cnt + 1;
    end
    vld_prev <= vld;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, output bit ok);
    int t = 0;
    while (nfr < target && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    ok = (nfr >= target);
  endtask

  task automatic wait_vld(input int target, output bit ok);
    int t = 0;
    while (nvld < target && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    ok = (nvld >= target);
  endtask

  task automatic set_regs(input logic [7:0] a4, input logic [7:0] a5,
                          input logic [7:0] ac, input logic [7:0] ad);
    reg_a4 = a4; reg_a5 = a5; reg_ac = ac; reg_ad = ad;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    wait_cycles(3);
    n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
    n_cmp++; if (SCLK !== 1'b1) begin n_err++; $display("FAIL reset_sclk: got %b want 1", SCLK); end
    n_cmp++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    n_cmp++; if (ptch_rt !== 16'h0000) begin n_err++; $display("FAIL reset_ptch: got %h want 0000", ptch_rt); end
    n_cmp++; if (AZ !== 16'h0000) begin n_err++; $display("FAIL reset_az: got %h want 0000", AZ); end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", vld); end
    rst = 1'b0;
  endtask

  task automatic test_pwrup();
    bit stayed = 1'b1;
    bit fell = 1'b0;
    repeat (62) begin
      @(negedge clk);
      if (SS_n !== 1'b1) stayed = 1'b0;
    end
    n_cmp++; if (!stayed) begin n_err++; $display("FAIL pwrup_quiet: got SS_n activity want none in 62 clk"); end
    repeat (10) begin
      @(negedge clk);
      if (SS_n === 1'b0) fell = 1'b1;
    end
    n_cmp++; if (!fell) begin n_err++; $display("FAIL pwrup_end: got SS_n high want first frame by clk 72"); end
  endtask

  task automatic test_cfg(input int base, input int v0);
    logic [15:0] exp_w [0:3];
    bit ok;
    exp_w[0] = 16'h0D02; exp_w[1] = 16'h1053; exp_w[2] = 16'h1150; exp_w[3] = 16'h1460;
    wait_frames(base + 4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL cfg_timeout: got %0d frames want %0d", nfr - base, 4); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (frames[base + i] !== exp_w[i]) begin
        n_err++; $display("FAIL cfg_word%0d: got %h want %h", i, frames[base + i], exp_w[i]);
      end
    end
    n_cmp++; if (nvld !== v0) begin n_err++; $display("FAIL cfg_vld: got %0d pulses want 0", nvld - v0); end
  endtask

  task automatic test_burst();
    int base = nfr;
    int v0 = nvld;
    bit ok;
    logic [15:0] exp_w [0:3];
    exp_w[0] = 16'hA400; exp_w[1] = 16'hA500; exp_w[2] = 16'hAC00; exp_w[3] = 16'hAD00;
    set_regs(8'h34, 8'h12, 8'hCD, 8'hAB);
    INT = 1'b1;
    wait_cycles(4);
    INT = 1'b0;
    wait_vld(v0 + 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL burst_timeout: got no vld want 1"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (frames[base + i] !== exp_w[i]) begin
        n_err++; $display("FAIL burst_word%0d: got %h want %h", i, frames[base + i], exp_w[i]);
      end
    end
    n_cmp++; if (ptch_rt !== 16'h1234) begin n_err++; $display("FAIL burst_ptch: got %h want 1234", ptch_rt); end
    n_cmp++; if (AZ !== 16'hABCD) begin n_err++; $display("FAIL burst_az: got %h want abcd", AZ); end
    set_regs(8'h99, 8'h99, 8'h99, 8'h99);
    wait_cycles(300);
    n_cmp++; if (nvld !== v0 + 1) begin n_err++; $display("FAIL burst_onevld: got %0d want 1", nvld - v0); end
    n_cmp++; if (ptch_rt !== 16'h1234 || AZ !== 16'hABCD) begin
      n_err++; $display("FAIL burst_hold: got %h/%h want 1234/abcd", ptch_rt, AZ);
    end
  endtask

  task automatic test_negative();
    int v0 = nvld;
    int sv;
    bit ok;
    set_regs(8'h00, 8'h80, 8'hFF, 8'h7F);
    INT = 1'b1;
    wait_cycles(4);
    INT = 1'b0;
    wait_vld(v0 + 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL neg_timeout: got no vld want 1"); end
    n_cmp++; if (ptch_rt !== 16'h8000) begin n_err++; $display("FAIL neg_ptch: got %h want 8000", ptch_rt); end
    sv = $signed(ptch_rt);
    n_cmp++; if (sv != -32768) begin n_err++; $display("FAIL neg_signed: got %0d want -32768", sv); end
    n_cmp++; if (AZ !== 16'h7FFF) begin n_err++; $display("FAIL neg_az: got %h want 7fff", AZ); end
  endtask

  task automatic test_int_during_cfg();
    int base, v0;
    bit ok;
    logic [15:0] exp_w [0:7];
    exp_w[0] = 16'h0D02; exp_w[1] = 16'h1053; exp_w[2] = 16'h1150; exp_w[3] = 16'h1460;
    exp_w[4] = 16'hA400; exp_w[5] = 16'hA500; exp_w[6] = 16'hAC00; exp_w[7] = 16'hAD00;
    set_regs(8'h34, 8'h12, 8'hCD, 8'hAB);
    do_reset();
    base = nfr;
    v0 = nvld;
    INT = 1'b1;
    wait_frames(base + 5, ok);
    INT = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL icfg_timeout: got %0d frames want 5", nfr - base); end
    wait_vld(v0 + 1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL icfg_vld: got no vld want 1"); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (frames[base + i] !== exp_w[i]) begin
        n_err++; $display("FAIL icfg_word%0d: got %h want %h", i, frames[base + i], exp_w[i]);
      end
    end
    n_cmp++; if (ptch_rt !== 16'h1234 || AZ !== 16'hABCD) begin
      n_err++; $display("FAIL icfg_data: got %h/%h want 1234/abcd", ptch_rt, AZ);
    end
  endtask

  task automatic test_back_to_back();
    int base = nfr;
    int v0 = nvld;
    bit ok;
    logic [15:0] exp_w [0:3];
    exp_w[0] = 16'hA400; exp_w[1] = 16'hA500; exp_w[2] = 16'hAC00; exp_w[3] = 16'hAD00;
    set_regs(8'h11, 8'h22, 8'h33, 8'h44);
    INT = 1'b1;
    wait_vld(v0 + 3, ok);
    INT = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d vld want 3", nvld - v0); end
    wait_vld(v0 + 4, ok);
    wait_cycles(50);
    n_cmp++; if (nvld !== v0 + 4) begin n_err++; $display("FAIL b2b_vldcnt: got %0d want 4", nvld - v0); end
    n_cmp++; if (nfr !== base + 16) begin n_err++; $display("FAIL b2b_frames: got %0d want 16", nfr - base); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (frames[base + i] !== exp_w[i % 4]) begin
        n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, frames[base + i], exp_w[i % 4]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_p[v0 + i] !== 16'h2211 || cap_a[v0 + i] !== 16'h4433) begin
        n_err++; $display("FAIL b2b_data%0d: got %h/%h want 2211/4433", i, cap_p[v0 + i], cap_a[v0 + i]);
      end
    end
    n_cmp++; if (wide_cnt !== 0) begin n_err++; $display("FAIL vld_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  task automatic test_reset_mid();
    int base = nfr;
    int v0 = nvld;
    int base2;
    bit ok;
    set_regs(8'h55, 8'h66, 8'h77, 8'h88);
    INT = 1'b1;
    wait_frames(base + 2, ok);
    INT = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_timeout: got %0d frames want 2", nfr - base); end
    wait_cycles(100);
    n_cmp++; if (SS_n !== 1'b0) begin n_err++; $display("FAIL mid_inframe: got SS_n=%b want 0", SS_n); end
    rst = 1'b1;
    #1;
    n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL mid_ss_n: got %b want 1", SS_n); end
    n_cmp++; if (ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin
      n_err++; $display("FAIL mid_outputs: got %h/%h want 0000/0000", ptch_rt, AZ);
    end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL mid_vld: got %b want 0", vld); end
    wait_cycles(3);
    rst = 1'b0;
    base2 = nfr;
    test_cfg(base2, v0);
    wait_cycles(300);
    n_cmp++; if (nvld !== v0) begin n_err++; $display("FAIL mid_novld: got %0d pulses want 0", nvld - v0); end
    n_cmp++; if (nfr !== base2 + 4) begin n_err++; $display("FAIL mid_noread: got %0d frames want 4", nfr - base2); end
  endtask

  initial begin
    test_reset();
    test_pwrup();
    test_cfg(0, 0);
    test_burst();
    test_negative();
    test_int_during_cfg();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
